// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: load-use bubbles, branch flushes,
// multi-cycle MUL/DIV holds and memory-busywait freezes.
module pipeline_stall_controller #(
   parameter int REG_AW         = 5,
   parameter int CNT_W          = 16,
   parameter int MULDIV_MAX_CYC = 40
) (
   input  logic              clk,
   input  logic              RESET,
   input  logic [REG_AW-1:0] id_rs1_addr,
   input  logic [REG_AW-1:0] id_rs2_addr,
   input  logic              id_uses_rs1,
   input  logic              id_uses_rs2,
   input  logic [REG_AW-1:0] ex_rd_addr,
   input  logic              ex_mem_read,
   input  logic              ex_muldiv,
   input  logic              muldiv_done,
   input  logic              branch_taken_ex,
   input  logic              imem_busywait,
   input  logic              dmem_busywait,
   output logic              pc_write_en,
   output logic              if_id_write_en,
   output logic              if_id_flush,
   output logic              id_ex_write_en,
   output logic              id_ex_bubble,
   output logic              ex_mem_write_en,
   output logic              ex_mem_bubble,
   output logic              mem_wb_write_en,
   output logic              muldiv_timeout_err,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic [1:0]        ctrl_state
);

   localparam logic [1:0] ST_RUN = 2'd0;
   localparam logic [1:0] ST_MDW = 2'd1;
   localparam logic [1:0] ST_FRZ = 2'd2;
   localparam int         TW     = $clog2(MULDIV_MAX_CYC + 1);

   logic [1:0]       state_q, state_d;
   logic [1:0]       ret_q, ret_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic             done_lat_q, done_lat_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             freeze, load_use, done_any, timeout;

   always_comb begin
      freeze   = imem_busywait | dmem_busywait;
      load_use = ex_mem_read && (ex_rd_addr != '0) &&
                 ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                  (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));
      done_any = muldiv_done | done_lat_q;
      timeout  = (timer_q == TW'(MULDIV_MAX_CYC - 1));

      pc_write_en     = 1'b1;
      if_id_write_en  = 1'b1;
      if_id_flush     = 1'b0;
      id_ex_write_en  = 1'b1;
      id_ex_bubble    = 1'b0;
      ex_mem_write_en = 1'b1;
      ex_mem_bubble   = 1'b0;
      mem_wb_write_en = 1'b1;
      state_d         = state_q;
      ret_d           = ret_q;
      timer_d         = timer_q;
      done_lat_d      = done_lat_q;
      err_d           = err_q;

      if (RESET) begin
         pc_write_en     = 1'b0;
         if_id_write_en  = 1'b0;
         id_ex_write_en  = 1'b0;
         ex_mem_write_en = 1'b0;
         mem_wb_write_en = 1'b0;
         if_id_flush     = 1'b1;
         id_ex_bubble    = 1'b1;
         ex_mem_bubble   = 1'b1;
         state_d         = ST_RUN;
         ret_d           = ST_RUN;
         timer_d         = '0;
         done_lat_d      = 1'b0;
         err_d           = 1'b0;
      end else if (freeze) begin
         pc_write_en     = 1'b0;
         if_id_write_en  = 1'b0;
         id_ex_write_en  = 1'b0;
         ex_mem_write_en = 1'b0;
         mem_wb_write_en = 1'b0;
         if (state_q != ST_FRZ) begin
            ret_d   = state_q;
            state_d = ST_FRZ;
         end
         // A done pulse seen while frozen must survive until MULDIV_WAIT resumes.
         if (muldiv_done && ((state_q == ST_MDW) || (state_q == ST_FRZ && ret_q == ST_MDW)))
            done_lat_d = 1'b1;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (branch_taken_ex) begin
                  if_id_flush  = 1'b1;
                  id_ex_bubble = 1'b1;
               end else if (ex_muldiv && !muldiv_done) begin
                  pc_write_en    = 1'b0;
                  if_id_write_en = 1'b0;
                  id_ex_write_en = 1'b0;
                  ex_mem_bubble  = 1'b1;
                  state_d        = ST_MDW;
                  timer_d        = '0;
               end else if (load_use) begin
                  pc_write_en    = 1'b0;
                  if_id_write_en = 1'b0;
                  id_ex_bubble   = 1'b1;
               end
            end
            ST_MDW: begin
               if (done_any) begin
                  state_d    = ST_RUN;
                  done_lat_d = 1'b0;
               end else if (timeout) begin
                  // Give up on the unit: release the pipeline but keep EX/MEM empty.
                  err_d         = 1'b1;
                  state_d       = ST_RUN;
                  ex_mem_bubble = 1'b1;
                  timer_d       = TW'(MULDIV_MAX_CYC);
               end else begin
                  pc_write_en    = 1'b0;
                  if_id_write_en = 1'b0;
                  id_ex_write_en = 1'b0;
                  ex_mem_bubble  = 1'b1;
                  if (timer_q != TW'(MULDIV_MAX_CYC))
                     timer_d = timer_q + TW'(1);
               end
            end
            ST_FRZ: begin
               // Return cycle: still held, resume the saved state on the next edge.
               pc_write_en     = 1'b0;
               if_id_write_en  = 1'b0;
               id_ex_write_en  = 1'b0;
               ex_mem_write_en = 1'b0;
               mem_wb_write_en = 1'b0;
               state_d         = ret_q;
               if (muldiv_done && ret_q == ST_MDW)
                  done_lat_d = 1'b1;
            end
            default: state_d = ST_RUN;
         endcase
      end

      stall_d = stall_q;
      if (RESET)
         stall_d = '0;
      else if (!pc_write_en && (stall_q != '1))
         stall_d = stall_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      timer_q    <= timer_d;
      done_lat_q <= done_lat_d;
      err_q      <= err_d;
      stall_q    <= stall_d;
   end

   assign muldiv_timeout_err = err_q;
   assign stall_cycles       = stall_q;
   assign ctrl_state         = state_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed-vector bench for pipeline_stall_controller (CNT_W=4, MULDIV_MAX_CYC=8).
module tb_pipeline_stall_controller;

   localparam int REG_AW = 5;
   localparam int CNT_W  = 4;
   localparam int MAXC   = 8;

   // {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, ex_mem_bubble, mem_wb_we}
   localparam logic [7:0] C_RST  = 8'b0010_1010;
   localparam logic [7:0] C_NORM = 8'b1101_0101;
   localparam logic [7:0] C_FRZ  = 8'b0000_0000;
   localparam logic [7:0] C_BR   = 8'b1111_1101;
   localparam logic [7:0] C_MDW  = 8'b0000_0111;
   localparam logic [7:0] C_LU   = 8'b0001_1101;
   localparam logic [7:0] C_TMO  = 8'b1101_0111;

   logic              clk = 1'b0;
   logic              RESET;
   logic [REG_AW-1:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
   logic              id_uses_rs1, id_uses_rs2, ex_mem_read, ex_muldiv, muldiv_done;
   logic              branch_taken_ex, imem_busywait, dmem_busywait;
   logic              pc_write_en, if_id_write_en, if_id_flush, id_ex_write_en, id_ex_bubble;
   logic              ex_mem_write_en, ex_mem_bubble, mem_wb_write_en, muldiv_timeout_err;
   logic [CNT_W-1:0]  stall_cycles;
   logic [1:0]        ctrl_state;
   logic [7:0]        ctl;

   int n_vec = 0;
   int n_err = 0;

   pipeline_stall_controller #(.REG_AW(REG_AW), .CNT_W(CNT_W), .MULDIV_MAX_CYC(MAXC)) dut (
      .clk(clk), .RESET(RESET),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read), .ex_muldiv(ex_muldiv),
      .muldiv_done(muldiv_done), .branch_taken_ex(branch_taken_ex),
      .imem_busywait(imem_busywait), .dmem_busywait(dmem_busywait),
      .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en), .if_id_flush(if_id_flush),
      .id_ex_write_en(id_ex_write_en), .id_ex_bubble(id_ex_bubble),
      .ex_mem_write_en(ex_mem_write_en), .ex_mem_bubble(ex_mem_bubble),
      .mem_wb_write_en(mem_wb_write_en), .muldiv_timeout_err(muldiv_timeout_err),
      .stall_cycles(stall_cycles), .ctrl_state(ctrl_state)
   );

   assign ctl = {pc_write_en, if_id_write_en, if_id_flush, id_ex_write_en,
                 id_ex_bubble, ex_mem_write_en, ex_mem_bubble, mem_wb_write_en};

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clr_in();
      id_rs1_addr = '0; id_rs2_addr = '0; ex_rd_addr = '0;
      id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
      ex_muldiv = 1'b0; muldiv_done = 1'b0; branch_taken_ex = 1'b0;
      imem_busywait = 1'b0; dmem_busywait = 1'b0;
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      clr_in();
      #1 chk("rst_ctl", 32'(ctl), 32'(C_RST));
      @(negedge clk);
      RESET = 1'b0;
      #1 chk("rst_state", 32'(ctrl_state), 0);
      chk("rst_stall", 32'(stall_cycles), 0);
      chk("rst_err", 32'(muldiv_timeout_err), 0);
   endtask

   initial begin
      RESET = 1'b1;
      clr_in();
      @(negedge clk);
      do_reset();

      // load-use: 1 bubble
      ex_mem_read = 1'b1; ex_rd_addr = 5'd5;
      id_rs1_addr = 5'd5; id_uses_rs1 = 1'b1; id_rs2_addr = 5'd7; id_uses_rs2 = 1'b1;
      #1 chk("lu_ctl", 32'(ctl), 32'(C_LU));
      chk("lu_state", 32'(ctrl_state), 0);
      @(negedge clk);
      ex_mem_read = 1'b0;
      #1 chk("lu_after_ctl", 32'(ctl), 32'(C_NORM));
      chk("lu_stall", 32'(stall_cycles), 1);
      @(negedge clk);

      // load to x0: no stall
      ex_mem_read = 1'b1; ex_rd_addr = 5'd0; id_rs1_addr = 5'd0; id_rs2_addr = 5'd0;
      #1 chk("x0_ctl", 32'(ctl), 32'(C_NORM));
      @(negedge clk);
      // rs2 matches but unused
      ex_rd_addr = 5'd5; id_rs1_addr = 5'd3; id_rs2_addr = 5'd5; id_uses_rs2 = 1'b0;
      #1 chk("rs2un_ctl", 32'(ctl), 32'(C_NORM));
      @(negedge clk);
      // branch beats load-use
      id_rs1_addr = 5'd5; branch_taken_ex = 1'b1;
      #1 chk("br_ctl", 32'(ctl), 32'(C_BR));
      @(negedge clk);
      clr_in();
      #1 chk("br_stall", 32'(stall_cycles), 1);

      // MUL/DIV: 4 waiting cycles, done on the 5th
      do_reset();
      ex_muldiv = 1'b1;
      #1 chk("md_entry_ctl", 32'(ctl), 32'(C_MDW));
      chk("md_entry_state", 32'(ctrl_state), 0);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         #1 chk("md_wait_ctl", 32'(ctl), 32'(C_MDW));
         chk("md_wait_state", 32'(ctrl_state), 1);
         @(negedge clk);
      end
      muldiv_done = 1'b1;
      #1 chk("md_done_ctl", 32'(ctl), 32'(C_NORM));
      chk("md_done_state", 32'(ctrl_state), 1);
      @(negedge clk);
      clr_in();
      #1 chk("md_run_state", 32'(ctrl_state), 0);
      chk("md_stall", 32'(stall_cycles), 5);

      // freeze inside MULDIV_WAIT, done arrives while frozen
      do_reset();
      ex_muldiv = 1'b1;
      #1 chk("fz_entry_ctl", 32'(ctl), 32'(C_MDW));
      @(negedge clk);
      #1 chk("fz_mdw_ctl", 32'(ctl), 32'(C_MDW));
      @(negedge clk);
      dmem_busywait = 1'b1;
      #1 chk("fz_c1_ctl", 32'(ctl), 32'(C_FRZ));
      chk("fz_c1_state", 32'(ctrl_state), 1);
      @(negedge clk);
      muldiv_done = 1'b1;
      #1 chk("fz_c2_state", 32'(ctrl_state), 2);
      @(negedge clk);
      muldiv_done = 1'b0;
      #1 chk("fz_c3_state", 32'(ctrl_state), 2);
      @(negedge clk);
      dmem_busywait = 1'b0;
      #1 chk("fz_ret_state", 32'(ctrl_state), 2);
      chk("fz_ret_ctl", 32'(ctl), 32'(C_FRZ));
      @(negedge clk);
      #1 chk("fz_done_state", 32'(ctrl_state), 1);
      chk("fz_done_ctl", 32'(ctl), 32'(C_NORM));
      @(negedge clk);
      ex_muldiv = 1'b0;
      #1 chk("fz_run_state", 32'(ctrl_state), 0);
      chk("fz_stall", 32'(stall_cycles), 6);

      // MUL/DIV timeout, then counter saturation
      do_reset();
      ex_muldiv = 1'b1;
      #1 chk("to_entry_ctl", 32'(ctl), 32'(C_MDW));
      @(negedge clk);
      for (int i = 0; i < MAXC - 1; i++) begin
         #1 chk("to_wait_ctl", 32'(ctl), 32'(C_MDW));
         chk("to_wait_err", 32'(muldiv_timeout_err), 0);
         @(negedge clk);
      end
      #1 chk("to_fire_ctl", 32'(ctl), 32'(C_TMO));
      chk("to_fire_state", 32'(ctrl_state), 1);
      @(negedge clk);
      ex_muldiv = 1'b0;
      #1 chk("to_err", 32'(muldiv_timeout_err), 1);
      chk("to_run_state", 32'(ctrl_state), 0);
      chk("to_stall", 32'(stall_cycles), 8);
      chk("to_run_ctl", 32'(ctl), 32'(C_NORM));
      @(negedge clk);
      imem_busywait = 1'b1;
      for (int i = 0; i < 10; i++) @(negedge clk);
      clr_in();
      #1 chk("sat_stall", 32'(stall_cycles), 15);
      chk("sat_err_sticky", 32'(muldiv_timeout_err), 1);
      @(negedge clk);
      do_reset();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
